mem_wb_hs: RTL

- Parametrised MEM->WB pipeline stage: replaces the free-running MEM/WB register with a valid/ready handshake stage.
- Has a 2-entry skid buffer, pipeline flush, and a write-back result mux registered inside the stage.
- Sits between the data-memory stage and the register-file write port; lets WB back-pressure MEM without a combinational ready path.

---
 rtl/mem_wb_hs.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mem_wb_hs.sv
// mem_wb_hs: MEM->WB pipeline stage with valid/ready handshake.
// Two storage slots: OUT drives the WB outputs, SKID catches the one entry
// that may arrive in the cycle WB stalls, because o_ready_M is registered.
// The write-back result is selected at accept time and stored, so WB sees
// a settled value straight from a flop.
// Optional feature macro: MEM_WB_PERF_EN adds saturating stall and
// flushed-entry counters; when it is undefined the counter outputs are tied
// to zero and no counter flops exist.
module mem_wb_hs #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_WIDTH  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid_M,
  output logic                  o_ready_M,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_alu_result_M,
  input  logic [DATA_WIDTH-1:0] i_read_data_M,
  input  logic [DATA_WIDTH-1:0] i_pc_plus4_M,
  input  logic [DATA_WIDTH-1:0] i_pc_target_M,
  input  logic [REG_WIDTH-1:0]  i_rd_M,
  input  logic                  i_reg_write_M,
  input  logic [1:0]            i_result_src_M,
  output logic                  o_valid_WB,
  input  logic                  i_ready_WB,
  output logic [DATA_WIDTH-1:0] o_result_WB,
  output logic [REG_WIDTH-1:0]  o_rd_WB,
  output logic                  o_reg_write_WB,
  output logic [CNT_WIDTH-1:0]  o_stall_cnt,
  output logic [CNT_WIDTH-1:0]  o_flush_cnt
);

  // Write-back source selection.
  function automatic logic [DATA_WIDTH-1:0] sel_result(
    input logic [1:0]            src,
    input logic [DATA_WIDTH-1:0] alu,
    input logic [DATA_WIDTH-1:0] rdata,
    input logic [DATA_WIDTH-1:0] pc4,
    input logic [DATA_WIDTH-1:0] tgt
  );
    logic [DATA_WIDTH-1:0] res;
    case (src)
      2'b00:   res = alu;
      2'b01:   res = rdata;
      2'b10:   res = pc4;
      default: res = tgt;
    endcase
    return res;
  endfunction

  // OUT slot (p1) and SKID slot.
  logic                  r_vld_p1;
  logic [DATA_WIDTH-1:0] r_result_p1;
  logic [REG_WIDTH-1:0]  r_rd_p1;
  logic                  r_rw_p1;

  logic                  r_skid_vld_p1;
  logic [DATA_WIDTH-1:0] r_skid_result_p1;
  logic [REG_WIDTH-1:0]  r_skid_rd_p1;
  logic                  r_skid_rw_p1;

  logic                  r_ready;

  logic                  w_accept;
  logic                  w_out_free;
  logic                  w_out_from_skid;
  logic                  w_out_from_in;
  logic                  w_skid_from_in;
  logic                  w_vld_nxt;
  logic                  w_skid_vld_nxt;
  logic [DATA_WIDTH-1:0] w_result_in;

  // Slot movement decisions for this cycle.
  always_comb begin
    w_accept        = i_valid_M & r_ready;
    w_out_free      = ~r_vld_p1 | i_ready_WB;
    w_out_from_skid = w_out_free & r_skid_vld_p1;
    w_out_from_in   = w_out_free & ~r_skid_vld_p1 & w_accept;
    w_skid_from_in  = w_accept & (r_skid_vld_p1 | ~w_out_free);
    w_vld_nxt       = w_out_free ? (r_skid_vld_p1 | w_accept) : 1'b1;
    w_skid_vld_nxt  = w_out_free ? (r_skid_vld_p1 & w_accept)
                                 : (r_skid_vld_p1 | w_accept);
    w_result_in     = sel_result(i_result_src_M, i_alu_result_M,
                                 i_read_data_M, i_pc_plus4_M, i_pc_target_M);
  end

  // Control: slot valids and the registered ready; reset and flush empty both slots.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_vld_p1      <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
      r_ready       <= 1'b1;
    end else begin
      r_vld_p1      <= w_vld_nxt;
      r_skid_vld_p1 <= w_skid_vld_nxt;
      r_ready       <= ~w_skid_vld_nxt;
    end
  end

  // ---- stage p1: OUT slot data, loaded from SKID first to keep order ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result_p1 <= '0;
      r_rd_p1     <= '0;
      r_rw_p1     <= 1'b0;
    end else if (!i_flush) begin
      if (w_out_from_skid) begin
        r_result_p1 <= r_skid_result_p1;
        r_rd_p1     <= r_skid_rd_p1;
        r_rw_p1     <= r_skid_rw_p1;
      end else if (w_out_from_in) begin
        r_result_p1 <= w_result_in;
        r_rd_p1     <= i_rd_M;
        r_rw_p1     <= i_reg_write_M;
      end
    end
  end

  // SKID slot data: only ever read while its valid is set, so no reset.
  always_ff @(posedge clk) begin
    if (!i_flush && w_skid_from_in) begin
      r_skid_result_p1 <= w_result_in;
      r_skid_rd_p1     <= i_rd_M;
      r_skid_rw_p1     <= i_reg_write_M;
    end
  end

  assign o_ready_M      = r_ready;
  assign o_valid_WB     = r_vld_p1;
  assign o_result_WB    = r_result_p1;
  assign o_rd_WB        = r_rd_p1;
  assign o_reg_write_WB = r_rw_p1 & r_vld_p1;

`ifdef MEM_WB_PERF_EN
  // Saturating add of a 0..2 increment.
  function automatic logic [CNT_WIDTH-1:0] sat_add(
    input logic [CNT_WIDTH-1:0] a,
    input logic [1:0]           b
  );
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {{(CNT_WIDTH-1){1'b0}}, b};
    return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
  endfunction

  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_flush_cnt;
  logic [1:0]           w_flush_inc;

  // Number of held entries a flush discards this cycle.
  always_comb begin
    w_flush_inc = {1'b0, r_vld_p1} + {1'b0, r_skid_vld_p1};
  end

  // Performance counters: stalled-output cycles and flushed held entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (r_vld_p1 && !i_ready_WB) begin
        r_stall_cnt <= sat_add(r_stall_cnt, 2'd1);
      end
      if (i_flush) begin
        r_flush_cnt <= sat_add(r_flush_cnt, w_flush_inc);
      end
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif

endmodule
